// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem handshake FSM
// (REQ/WAIT/HOLD/DROP) and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  PCSrcE,
  input  logic [31:0] TargetD,
  input  logic [31:0] RecoverPCE,
  input  logic        StallD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        branched_flag_F
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_hold;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic [31:0] r_pc4_d;
  logic        r_valid_d;
  logic        r_branched;
  logic        r_stale;

  logic        w_take_target;
  logic        w_redirect;
  logic [31:0] w_redirect_pc;
  logic [31:0] w_pc_plus4;
  logic        w_accept;
  logic        w_write;
  logic        w_capture;
  logic [31:0] w_write_data;

  assign w_take_target = (PCSrcE == 2'b01);
  assign w_redirect    = w_take_target || (PCSrcE == 2'b10);
  assign w_redirect_pc = w_take_target ? TargetD : RecoverPCE;
  assign w_pc_plus4    = r_pc + 32'd4;

  // A response still owed from before reset must drain before a new request,
  // otherwise it could be mistaken for the answer to the new one.
  assign imem_req  = reset_n && (r_state == S_REQ) && !r_stale;
  assign imem_addr = r_pc;
  assign w_accept  = imem_req && imem_ready;

  always_comb begin
    w_state_nxt  = r_state;
    w_write      = 1'b0;
    w_capture    = 1'b0;
    w_write_data = imem_rdata;
    case (r_state)
      S_REQ: begin
        if (w_accept) begin
          w_state_nxt = w_redirect ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (w_redirect) begin
          w_state_nxt = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          if (StallD) begin
            w_capture   = 1'b1;
            w_state_nxt = S_HOLD;
          end else begin
            w_write     = 1'b1;
            w_state_nxt = S_REQ;
          end
        end
      end
      S_HOLD: begin
        w_write_data = r_hold;
        if (w_redirect) begin
          w_state_nxt = S_REQ;
        end else if (!StallD) begin
          w_write     = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Remembers across reset that a response is still in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stale <= ((r_state == S_WAIT) || (r_state == S_DROP) || r_stale) && !imem_rvalid;
    end else if (imem_rvalid) begin
      r_stale <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc       <= RESET_PC;
      r_branched <= 1'b0;
    end else if (w_redirect) begin
      r_pc       <= w_redirect_pc;
      r_branched <= w_take_target;
    end else if (w_write) begin
      r_pc       <= w_pc_plus4;
      r_branched <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_hold <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_instr_d <= NOP_INSTR;
      r_pc_d    <= '0;
      r_pc4_d   <= '0;
      r_valid_d <= 1'b0;
    end else if (w_redirect) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end else if (w_write) begin
      r_instr_d <= w_write_data;
      r_pc_d    <= r_pc;
      r_pc4_d   <= w_pc_plus4;
      r_valid_d <= 1'b1;
    end else if (!StallD) begin
      r_instr_d <= NOP_INSTR;
      r_valid_d <= 1'b0;
    end
  end

  assign InstrD          = r_instr_d;
  assign PCD             = r_pc_d;
  assign PCPlus4D        = r_pc4_d;
  assign ValidD          = r_valid_d;
  assign branched_flag_F = r_branched;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: behavioural instruction memory, scoreboard of expected
// IF/ID writes, a redirect vector table and directed multi-cycle sequences.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  PCSrcE;
  logic [31:0] TargetD;
  logic [31:0] RecoverPCE;
  logic        StallD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
  logic        branched_flag_F;

  fetch_stage #(
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .PCSrcE          (PCSrcE),
    .TargetD         (TargetD),
    .RecoverPCE      (RecoverPCE),
    .StallD          (StallD),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .InstrD          (InstrD),
    .PCD             (PCD),
    .PCPlus4D        (PCPlus4D),
    .ValidD          (ValidD),
    .branched_flag_F (branched_flag_F)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // memory model state
  int unsigned mem_lat  = 1;
  bit          mem_pend = 1'b0;
  logic [31:0] mem_addr = '0;
  int unsigned mem_cnt  = 0;

  // scoreboard
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;
  exp_t        sbq[$];
  bit          sb_push  = 1'b0;
  bit          sb_check = 1'b0;
  int unsigned n_writes = 0;

  typedef struct {
    logic [1:0]  src;
    logic [31:0] tgt;
    logic [31:0] rec;
    int unsigned lat;
    logic [31:0] exp_addr;
    logic        exp_br;
    logic        exp_req;
  } rd_vec_t;
  rd_vec_t rd_tab[5];

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // One clock: drive the memory response, take the edge, update the memory
  // model and scoreboard, and return at the following falling edge.
  task automatic cyc();
    bit          rv_now;
    bit          acc;
    bit          stall_e;
    logic [31:0] aaddr;
    exp_t        e;
    rv_now      = mem_pend && (mem_cnt == 0);
    imem_rvalid = rv_now;
    imem_rdata  = rv_now ? word(mem_addr) : 32'hDEAD_BEEF;
    #1;
    acc     = imem_req && imem_ready;
    aaddr   = imem_addr;
    stall_e = StallD;
    @(posedge clk);
    if (rv_now) mem_pend = 1'b0;
    else if (mem_pend && mem_cnt > 0) mem_cnt--;
    if (acc) begin
      chk("one_outstanding", 32'(mem_pend), 32'd0);
      mem_pend = 1'b1;
      mem_addr = aaddr;
      mem_cnt  = mem_lat - 1;
      if (sb_push) sbq.push_back('{word(aaddr), aaddr, aaddr + 32'd4});
    end
    #1;
    if (sb_check && !stall_e && ValidD) begin
      n_writes++;
      if (sbq.size() == 0) begin
        n_checks++;
        $display("FAIL sb_unexpected: got write PCD=%h expected none", PCD);
      end else begin
        e = sbq.pop_front();
        chk("sb_instr", InstrD, e.instr);
        chk("sb_pcd", PCD, e.pc);
        chk("sb_pc4", PCPlus4D, e.pc4);
      end
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rd_tab[0] = '{2'b01, 32'h0000_0100, 32'h0,         2, 32'h0000_0100, 1'b1, 1'b0};
    rd_tab[1] = '{2'b10, 32'h0,         32'h0000_0044, 2, 32'h0000_0044, 1'b0, 1'b0};
    rd_tab[2] = '{2'b01, 32'h0000_0200, 32'h0,         1, 32'h0000_0200, 1'b1, 1'b1};
    rd_tab[3] = '{2'b10, 32'h0,         32'h0000_0300, 1, 32'h0000_0300, 1'b0, 1'b1};
    rd_tab[4] = '{2'b01, 32'hFFFF_FFFC, 32'h0,         2, 32'hFFFF_FFFC, 1'b1, 1'b0};

    reset_n = 1'b0; PCSrcE = 2'b00; TargetD = '0; RecoverPCE = '0; StallD = 1'b0;
    imem_ready = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    @(negedge clk);
    cyc(); cyc();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_valid", 32'(ValidD), 32'd0);
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 32'd0);
    chk("rst_pc4", PCPlus4D, 32'd0);
    chk("rst_br", 32'(branched_flag_F), 32'd0);

    // first fetch after reset release
    reset_n = 1'b1; #1;
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, RST_PC);
    cyc();
    chk("rel_wait_req", 32'(imem_req), 32'd0);
    chk("rel_wait_valid", 32'(ValidD), 32'd0);
    cyc();
    chk("rel_instr", InstrD, word(RST_PC));
    chk("rel_pcd", PCD, RST_PC);
    chk("rel_pc4", PCPlus4D, RST_PC + 32'd4);
    chk("rel_valid", 32'(ValidD), 32'd1);
    chk("rel_next_addr", imem_addr, RST_PC + 32'd4);

    // zero-wait stream with PCSrcE=11: one instruction every two cycles
    PCSrcE = 2'b11; sb_push = 1'b1; sb_check = 1'b1; n_writes = 0;
    for (int i = 0; i < 16; i++) cyc();
    chk("throughput", n_writes, 32'd8);
    chk("sb_drain", 32'(sbq.size()), 32'd0);
    sb_push = 1'b0; sb_check = 1'b0; PCSrcE = 2'b00;
    chk("stream_addr", imem_addr, 32'h24);

    // stall for three cycles while the response arrives
    cyc();
    chk("stl_pre_valid", 32'(ValidD), 32'd0);
    StallD = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stl_valid", 32'(ValidD), 32'd0);
      chk("stl_instr", InstrD, NOP);
      chk("stl_req", 32'(imem_req), 32'd0);
    end
    StallD = 1'b0;
    cyc();
    chk("stl_instr_out", InstrD, word(32'h24));
    chk("stl_pcd", PCD, 32'h24);
    chk("stl_pc4", PCPlus4D, 32'h28);
    chk("stl_valid_out", 32'(ValidD), 32'd1);
    chk("stl_next_addr", imem_addr, 32'h28);

    // redirect while a word is held: held word is discarded, bubble overrides stall
    cyc();
    StallD = 1'b1;
    cyc();
    PCSrcE = 2'b10; RecoverPCE = 32'h80;
    cyc();
    chk("hold_rd_valid", 32'(ValidD), 32'd0);
    chk("hold_rd_instr", InstrD, NOP);
    chk("hold_rd_addr", imem_addr, 32'h80);
    chk("hold_rd_req", 32'(imem_req), 32'd1);
    PCSrcE = 2'b00; StallD = 1'b0;
    cyc(); cyc();
    chk("hold_rd_instr2", InstrD, word(32'h80));
    chk("hold_rd_pcd", PCD, 32'h80);

    // redirect table: redirect arrives in WAIT, with or without the response
    for (int v = 0; v < 5; v++) begin
      mem_lat = rd_tab[v].lat;
      cyc();
      PCSrcE = rd_tab[v].src; TargetD = rd_tab[v].tgt; RecoverPCE = rd_tab[v].rec;
      cyc();
      chk("rd_addr", imem_addr, rd_tab[v].exp_addr);
      chk("rd_br", 32'(branched_flag_F), 32'(rd_tab[v].exp_br));
      chk("rd_valid", 32'(ValidD), 32'd0);
      chk("rd_instr", InstrD, NOP);
      chk("rd_req", 32'(imem_req), 32'(rd_tab[v].exp_req));
      PCSrcE = 2'b00;
      for (int k = 0; k < 8 && !imem_req; k++) begin
        cyc();
        chk("rd_drop_valid", 32'(ValidD), 32'd0);
      end
      chk("rd_resume_req", 32'(imem_req), 32'd1);
      chk("rd_resume_addr", imem_addr, rd_tab[v].exp_addr);
    end

    // PC wrap at the top of the address space
    mem_lat = 1;
    cyc(); cyc();
    chk("wrap_instr", InstrD, word(32'hFFFF_FFFC));
    chk("wrap_pcd", PCD, 32'hFFFF_FFFC);
    chk("wrap_pc4", PCPlus4D, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_br", 32'(branched_flag_F), 32'd0);

    // redirect in REQ while memory is not ready
    imem_ready = 1'b0; PCSrcE = 2'b01; TargetD = 32'h500;
    cyc();
    chk("reqrd_addr", imem_addr, 32'h500);
    chk("reqrd_req", 32'(imem_req), 32'd1);
    chk("reqrd_br", 32'(branched_flag_F), 32'd1);
    chk("reqrd_valid", 32'(ValidD), 32'd0);
    PCSrcE = 2'b00;
    cyc();
    chk("reqrd_hold_addr", imem_addr, 32'h500);
    chk("reqrd_hold_req", 32'(imem_req), 32'd1);
    imem_ready = 1'b1;
    cyc(); cyc();
    chk("reqrd_instr", InstrD, word(32'h500));
    chk("reqrd_pcd", PCD, 32'h500);

    // acceptance and redirect on the same edge
    PCSrcE = 2'b10; RecoverPCE = 32'h600;
    cyc();
    chk("accrd_addr", imem_addr, 32'h600);
    chk("accrd_req", 32'(imem_req), 32'd0);
    chk("accrd_br", 32'(branched_flag_F), 32'd0);
    PCSrcE = 2'b00;
    cyc();
    chk("accrd_drop_valid", 32'(ValidD), 32'd0);
    chk("accrd_resume_req", 32'(imem_req), 32'd1);
    chk("accrd_resume_addr", imem_addr, 32'h600);

    // reset while in DROP; the late response must be ignored
    mem_lat = 4;
    cyc();
    PCSrcE = 2'b01; TargetD = 32'h700;
    cyc();
    chk("rdrop_req", 32'(imem_req), 32'd0);
    PCSrcE = 2'b00; reset_n = 1'b0;
    cyc();
    chk("rdrop_addr", imem_addr, RST_PC);
    chk("rdrop_valid", 32'(ValidD), 32'd0);
    chk("rdrop_instr", InstrD, NOP);
    chk("rdrop_br", 32'(branched_flag_F), 32'd0);
    reset_n = 1'b1; mem_lat = 1;
    for (int k = 0; k < 12 && !ValidD; k++) cyc();
    chk("rdrop_restart_valid", 32'(ValidD), 32'd1);
    chk("rdrop_restart_pcd", PCD, RST_PC);
    chk("rdrop_restart_instr", InstrD, word(RST_PC));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
